// File: rtl/fifo_rr_scheduler.sv
// Round-robin burst scheduler draining CH_NUM showahead FIFOs into one registered valid/ready stream.
// Optional saturating statistics counters are enabled with `define FIFO_SCHED_STATS_EN.
module fifo_rr_scheduler #(
  parameter  int CH_NUM    = 4,
  parameter  int DWIDTH    = 64,
  parameter  int BURST_LEN = 8,
  localparam int CHW       = $clog2(CH_NUM)
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [CH_NUM-1:0]        fifo_empty_i,
  input  logic [CH_NUM*DWIDTH-1:0] fifo_q_i,
  output logic [CH_NUM-1:0]        fifo_rdreq_o,
  input  logic [CH_NUM-1:0]        ch_en_i,
  output logic [DWIDTH-1:0]        data_o,
  output logic [CHW-1:0]           chan_o,
  output logic                     valid_o,
  input  logic                     ready_i,
`ifdef FIFO_SCHED_STATS_EN
  output logic [31:0]              stat_words_o,
  output logic [31:0]              stat_stall_o,
`endif
  output logic                     busy_o
);

  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t             state_q, state_d;
  logic [CHW-1:0]     g_q, g_d;
  logic [CHW-1:0]     last_q, last_d;
  logic [BCW-1:0]     burst_q, burst_d;
  logic               valid_q;
  logic [DWIDTH-1:0]  data_q;
  logic [CHW-1:0]     chan_q;

  logic [CH_NUM-1:0]  req;
  logic [CHW-1:0]     sel;
  logic               found;
  logic [DWIDTH-1:0]  q_sel;
  logic               load;

  assign req = ~fifo_empty_i & ch_en_i;

  // First requesting channel after the last grant, wrapping around.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 1; i <= CH_NUM; i++) begin
      int unsigned idx;
      idx = (int'(last_q) + i) % CH_NUM;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = CHW'(idx);
      end
    end
  end

  always_comb begin
    q_sel = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (g_q == CHW'(k)) q_sel = fifo_q_i[k*DWIDTH +: DWIDTH];
    end
  end

  // Reset gates the pop so no word leaves a FIFO only to be discarded.
  assign load = (state_q == S_GRANT) && !fifo_empty_i[g_q] && ch_en_i[g_q] &&
                (!valid_q || ready_i) && !srst_i;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      last_q  <= CHW'(CH_NUM - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GRANT;
          g_d     = sel;
          last_d  = sel;
          burst_d = '0;
        end
      end
      S_GRANT: begin
        if (load) burst_d = burst_q + 1'b1;
        if ((load && burst_q == BCW'(BURST_LEN - 1)) || fifo_empty_i[g_q] || !ch_en_i[g_q])
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_rdreq_o = '0;
    if (load) fifo_rdreq_o[g_q] = 1'b1;
    busy_o = (state_q == S_GRANT);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= q_sel;
      chan_q  <= g_q;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign chan_o  = chan_q;

`ifdef FIFO_SCHED_STATS_EN
  logic [31:0] words_q, stall_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (valid_q && ready_i && words_q != 32'hFFFF_FFFF) words_q <= words_q + 32'd1;
      if (valid_q && !ready_i && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_words_o = words_q;
  assign stat_stall_o = stall_q;
`endif

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler: queue-based FIFO models, an expected-word scoreboard
// checked every cycle, and literal checks on latency, burst spacing and reset behaviour.
module tb_fifo_rr_scheduler;

  localparam int CH = 4;
  localparam int DW = 64;
  localparam int BL = 8;

  logic              clk_i = 1'b0;
  logic              srst_i;
  logic [CH-1:0]     fifo_empty_i;
  logic [CH*DW-1:0]  fifo_q_i;
  logic [CH-1:0]     fifo_rdreq_o;
  logic [CH-1:0]     ch_en_i;
  logic [DW-1:0]     data_o;
  logic [1:0]        chan_o;
  logic              valid_o;
  logic              ready_i;
  logic              busy_o;
`ifdef FIFO_SCHED_STATS_EN
  logic [31:0]       stat_words_o;
  logic [31:0]       stat_stall_o;
`endif

  fifo_rr_scheduler #(.CH_NUM(CH), .DWIDTH(DW), .BURST_LEN(BL)) dut (
    .clk_i        (clk_i),
    .srst_i       (srst_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_q_i     (fifo_q_i),
    .fifo_rdreq_o (fifo_rdreq_o),
    .ch_en_i      (ch_en_i),
    .data_o       (data_o),
    .chan_o       (chan_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
`ifdef FIFO_SCHED_STATS_EN
    .stat_words_o (stat_words_o),
    .stat_stall_o (stat_stall_o),
`endif
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [63:0] d; logic [1:0] c; } exp_t;

  logic [63:0] fq [CH][$];
  exp_t        exp_q[$];
  int          xfer_cyc[$];
  int          total = 0, bad = 0, cyc = 0, n_xfer = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [1:0]  prev_chan;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifos();
    for (int k = 0; k < CH; k++) begin
      fifo_empty_i[k] = (fq[k].size() == 0);
      fifo_q_i[k*DW +: DW] = (fq[k].size() != 0) ? fq[k][0] : 64'd0;
    end
  endtask

  task automatic fill(input int ch, input int first, input int n);
    for (int i = 0; i < n; i++) fq[ch].push_back(64'(first + i));
    drive_fifos();
  endtask

  task automatic expect_words(input int ch, input int first, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d = 64'(first + i);
      e.c = 2'(ch);
      exp_q.push_back(e);
    end
  endtask

  // One clock: check the settled outputs against the scoreboard and rules, then pop popped FIFOs.
  task automatic step();
    logic [CH-1:0] rd;
    exp_t e;
    #1;
    rd = fifo_rdreq_o;
    chk("rd_onehot", 64'($onehot0(rd)), 64'd1);
    chk("rd_legal", 64'(rd & (fifo_empty_i | ~ch_en_i)), 64'd0);
    if (valid_o && !ready_i) chk("rd_in_stall", 64'(rd), 64'd0);
    if (rd != '0) chk("rd_busy", 64'(busy_o), 64'd1);
    if (prev_stall) begin
      chk("hold_data", data_o, prev_data);
      chk("hold_chan", 64'(chan_o), 64'(prev_chan));
    end
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_word act=%0h chan=%0d exp=none", data_o, chan_o);
      end else begin
        e = exp_q.pop_front();
        chk("data", data_o, e.d);
        chk("chan", 64'(chan_o), 64'(e.c));
      end
      n_xfer++;
      xfer_cyc.push_back(cyc);
    end
    prev_stall = valid_o && !ready_i;
    prev_data  = data_o;
    prev_chan  = chan_o;
    @(posedge clk_i);
    #1;
    cyc++;
    for (int k = 0; k < CH; k++)
      if (rd[k] && fq[k].size() != 0) void'(fq[k].pop_front());
    drive_fifos();
  endtask

  task automatic reset_dut();
    for (int k = 0; k < CH; k++) fq[k].delete();
    exp_q.delete();
    xfer_cyc.delete();
    drive_fifos();
    srst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    srst_i = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || valid_o) && n < budget) begin
      step();
      n++;
    end
    total++;
    if (exp_q.size() != 0 || valid_o) begin
      bad++;
      $display("FAIL %s_timeout act=%0d_left exp=0_left", name, exp_q.size());
    end
    repeat (4) step();
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int n = 0;
    while (n_xfer < target && n < budget) begin
      step();
      n++;
    end
    chk("wait_xfers", 64'(n_xfer >= target), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    srst_i  = 1'b1;
    ready_i = 1'b1;
    ch_en_i = 4'b1111;
    fifo_empty_i = '1;
    fifo_q_i = '0;

    // Idle with all FIFOs empty
    reset_dut();
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_data", data_o, 64'd0);
    chk("rst_chan", 64'(chan_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_rd", 64'(fifo_rdreq_o), 64'd0);
      chk("idle_valid", 64'(valid_o), 64'd0);
      chk("idle_busy", 64'(busy_o), 64'd0);
    end

    // Single channel: 20 words in bursts of 8 with one bubble between bursts
    reset_dut();
    fill(0, 0, 20);
    expect_words(0, 0, 20);
    step();
    chk("lat_busy", 64'(busy_o), 64'd1);
    chk("lat_rd", 64'(fifo_rdreq_o), 64'd1);
    chk("lat_valid0", 64'(valid_o), 64'd0);
    step();
    chk("lat_valid1", 64'(valid_o), 64'd1);
    chk("lat_data", data_o, 64'd0);
    drain("single", 100);
    chk("single_count", 64'(xfer_cyc.size()), 64'd20);
    if (xfer_cyc.size() == 20)
      for (int i = 0; i < 20; i++)
        chk("burst_spacing", 64'(xfer_cyc[i] - xfer_cyc[0]),
            64'((i < 8) ? i : (i < 16) ? i + 1 : i + 2));

    // Four channels, three words each: rotation 0,1,2,3
    reset_dut();
    for (int c = 0; c < CH; c++) begin
      fill(c, c * 16, 3);
      expect_words(c, c * 16, 3);
    end
    drain("rotate", 100);

    // Channel 2 disabled, then enabled during channel 1's burst
    reset_dut();
    ch_en_i = 4'b1011;
    fill(1, 16, 12);
    fill(2, 32, 12);
    expect_words(1, 16, 8);
    expect_words(2, 32, 8);
    expect_words(1, 24, 4);
    expect_words(2, 40, 4);
    n_xfer = 0;
    wait_xfers(3, 20);
    ch_en_i = 4'b1111;
    drain("enable", 200);

    // Downstream stall on channel 3
    reset_dut();
    fill(3, 48, 5);
    expect_words(3, 48, 5);
    begin
      int n = 0;
      while (!valid_o && n < 10) begin
        step();
        n++;
      end
    end
    chk("stall_first_valid", 64'(valid_o), 64'd1);
    ready_i = 1'b0;
    repeat (6) step();
    chk("stall_data", data_o, 64'd48);
    chk("stall_chan", 64'(chan_o), 64'd3);
    chk("stall_left", 64'(fq[3].size()), 64'd4);
    ready_i = 1'b1;
    drain("stall", 50);

    // Reset during a channel 2 burst restarts rotation from channel 0
    reset_dut();
    fill(2, 32, 10);
    expect_words(2, 32, 4);
    n_xfer = 0;
    wait_xfers(1, 20);
    fill(1, 16, 3);
    fill(3, 48, 2);
    wait_xfers(3, 20);
    srst_i = 1'b1;
    step();
    srst_i = 1'b0;
    chk("srst_valid", 64'(valid_o), 64'd0);
    chk("srst_busy", 64'(busy_o), 64'd0);
    chk("srst_ch2_left", 64'(fq[2].size()), 64'd6);
`ifdef FIFO_SCHED_STATS_EN
    chk("stat_words_rst", 64'(stat_words_o), 64'd0);
    chk("stat_stall_rst", 64'(stat_stall_o), 64'd0);
`endif
    expect_words(1, 16, 3);
    expect_words(2, 36, 6);
    expect_words(3, 48, 2);
    drain("srst", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
